// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and helpers for the LITE-16 register-file write path.
package lite16_pkg;

    localparam int NREG = 16;
    localparam int DW   = 16;
    localparam int AW   = 4;

    // Requester slots on the write port
    localparam int REQ_EXE = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_DBG = 2;

    // One-hot decode of a register index
    function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter.sv
// Round-robin grant over NREQ requesters. The search starts one past the
// last granted index, so the most recent winner has lowest priority.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            grant_any
);

    logic [PW-1:0] ptr;
    int            cand;

    // First valid requester after ptr, wrapping; nothing granted during reset
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (rst && !grant_any && req_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = PW'(cand);
                grant_any   = 1'b1;
            end
        end
    end

    // Pointer remembers the last winner; reset value makes requester 0 first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= PW'(NREQ - 1);
        else if (grant_any)
            ptr <= grant_idx;
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Owns the register-file write port: arbitrates writers, registers the
// data/one-hot enable pair, and keeps the pending-write scoreboard used
// for operand hazards and WAW reservation stalls.
module regfile_write_scheduler
    import lite16_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic               rsv_valid,
    input  logic [AW-1:0]      rsv_addr,
    output logic               rsv_ready,
    input  logic [AW-1:0]      chk_a,
    input  logic [AW-1:0]      chk_b,
    input  logic               chk_valid,
    output logic               hazard,
    input  logic               flush,
    output logic [NREG-1:0]    wr_en,
    output logic [DW-1:0]      wr_data,
    output logic [NREG-1:0]    pending
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] pending_nxt;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .grant     (req_ready),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Route the winner's address and data to the output registers
    always_comb begin
        sel_addr = req_addr[int'(grant_idx)*AW +: AW];
        sel_data = req_data[int'(grant_idx)*DW +: DW];
    end

    // Reservation check sees only the current scoreboard, never a same-cycle clear
    assign rsv_ready = rsv_valid & ~pending[rsv_addr] & ~flush;
    assign hazard    = chk_valid & (pending[chk_a] | pending[chk_b]);

    // Next scoreboard: clear on the capture edge, set wins over clear, flush wins over all
    always_comb begin
        pending_nxt = (pending & ~wr_en) | (rsv_ready ? onehot(rsv_addr) : '0);
        if (flush)
            pending_nxt = '0;
    end

    // Write-port registers; data holds when idle so only the enable toggles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= '0;
            wr_data <= '0;
        end else if (grant_any) begin
            wr_en   <= onehot(sel_addr);
            wr_data <= sel_data;
        end else begin
            wr_en   <= '0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= '0;
        else
            pending <= pending_nxt;
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: vector table, directed multi-cycle
// sequences and a randomized run against a cycle-level reference model.
module tb_regfile_write_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic        rsv_valid;
    logic [3:0]  rsv_addr;
    logic        rsv_ready;
    logic [3:0]  chk_a, chk_b;
    logic        chk_valid;
    logic        hazard;
    logic        flush;
    logic [15:0] wr_en;
    logic [15:0] wr_data;
    logic [15:0] pending;

    logic [3:0]  ra [3];
    logic [15:0] rd [3];
    assign req_addr = {ra[2], ra[1], ra[0]};
    assign req_data = {rd[2], rd[1], rd[0]};

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [15:0] m_pending, m_wr_en, m_wr_data;
    int          m_last;

    regfile_write_scheduler #(.NREQ(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
        .chk_a(chk_a), .chk_b(chk_b), .chk_valid(chk_valid), .hazard(hazard),
        .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rv;
        logic [11:0] a;
        logic [47:0] d;
        logic [2:0]  er;
        logic [15:0] ewe;
        logic [15:0] ewd;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_grant();
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (m_last + k) % 3;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_pending = '0;
        m_wr_en   = '0;
        m_wr_data = '0;
        m_last    = 2;
    endtask

    task automatic model_check();
        logic [2:0] er;
        int g;
        er = '0;
        g  = model_grant();
        if (rst && g >= 0) er[g] = 1'b1;
        chk("m_req_ready", {29'd0, req_ready}, {29'd0, er});
        chk("m_rsv_ready", {31'd0, rsv_ready},
            {31'd0, rsv_valid && !m_pending[rsv_addr] && !flush});
        chk("m_hazard", {31'd0, hazard},
            {31'd0, chk_valid && (m_pending[chk_a] || m_pending[chk_b])});
        chk("m_wr_en", {16'd0, wr_en}, {16'd0, m_wr_en});
        chk("m_wr_data", {16'd0, wr_data}, {16'd0, m_wr_data});
        chk("m_pending", {16'd0, pending}, {16'd0, m_pending});
    endtask

    task automatic model_update();
        logic [15:0] set, nxt;
        int g;
        if (!rst) begin
            model_reset();
        end else begin
            set = '0;
            if (rsv_valid && !m_pending[rsv_addr] && !flush) set[rsv_addr] = 1'b1;
            nxt = flush ? 16'h0 : ((m_pending & ~m_wr_en) | set);
            g = model_grant();
            if (g >= 0) begin
                m_wr_en   = 16'h1 << ra[g];
                m_wr_data = rd[g];
                m_last    = g;
            end else begin
                m_wr_en = '0;
            end
            m_pending = nxt;
        end
    endtask

    task automatic settle();
        #2;
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        chk_a     = '0;
        chk_b     = '0;
        chk_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        model_reset();

        tbl[0] = '{3'b111, 12'h321, 48'h3333_2222_1111, 3'b001, 16'h0000, 16'h0000};
        tbl[1] = '{3'b111, 12'h321, 48'h3333_2222_1111, 3'b010, 16'h0002, 16'h1111};
        tbl[2] = '{3'b111, 12'h321, 48'h3333_2222_1111, 3'b100, 16'h0004, 16'h2222};
        tbl[3] = '{3'b111, 12'h321, 48'h3333_2222_1111, 3'b001, 16'h0008, 16'h3333};
        tbl[4] = '{3'b111, 12'h321, 48'h3333_2222_1111, 3'b010, 16'h0002, 16'h1111};
        tbl[5] = '{3'b111, 12'h321, 48'h3333_2222_1111, 3'b100, 16'h0004, 16'h2222};
        tbl[6] = '{3'b001, 12'h005, 48'h0000_0000_BEEF, 3'b001, 16'h0008, 16'h3333};
        tbl[7] = '{3'b000, 12'h000, 48'h0,              3'b000, 16'h0020, 16'hBEEF};
        tbl[8] = '{3'b000, 12'h000, 48'h0,              3'b000, 16'h0000, 16'hBEEF};

        // reset state
        #2;
        req_valid = 3'b111;
        #1;
        chk("rst_wr_en", {16'd0, wr_en}, 32'h0);
        chk("rst_wr_data", {16'd0, wr_data}, 32'h0);
        chk("rst_pending", {16'd0, pending}, 32'h0);
        chk("rst_req_ready", {29'd0, req_ready}, 32'h0);
        req_valid = '0;
        adv();
        rst = 1'b1;

        // round robin then single write
        for (int i = 0; i < 9; i++) begin
            req_valid = tbl[i].rv;
            for (int j = 0; j < 3; j++) begin
                ra[j] = tbl[i].a[j*4 +: 4];
                rd[j] = tbl[i].d[j*16 +: 16];
            end
            settle();
            chk("tbl_req_ready", {29'd0, req_ready}, {29'd0, tbl[i].er});
            chk("tbl_wr_en", {16'd0, wr_en}, {16'd0, tbl[i].ewe});
            chk("tbl_wr_data", {16'd0, wr_data}, {16'd0, tbl[i].ewd});
            adv();
        end

        // scoreboard lifecycle on r7
        idle();
        rsv_valid = 1'b1; rsv_addr = 4'd7;
        settle(); chk("sb_rsv_ready", {31'd0, rsv_ready}, 32'd1);
        adv();
        rsv_valid = 1'b0; chk_a = 4'd7; chk_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 3) begin req_valid = 3'b001; ra[0] = 4'd7; rd[0] = 16'hA5A5; end
            else req_valid = 3'b000;
            settle();
            chk("sb_pending7", {31'd0, pending[7]}, 32'd1);
            chk("sb_hazard", {31'd0, hazard}, 32'd1);
            if (c == 4) chk("sb_wr_en", {16'd0, wr_en}, 32'h0080);
            adv();
        end
        settle();
        chk("sb_hazard_clr", {31'd0, hazard}, 32'd0);
        chk("sb_pending7_clr", {31'd0, pending[7]}, 32'd0);
        adv();

        // WAW stall on r3
        idle();
        rsv_valid = 1'b1; rsv_addr = 4'd3;
        settle(); chk("waw_first_rsv", {31'd0, rsv_ready}, 32'd1);
        adv();
        chk_b = 4'd3; chk_valid = 1'b1;
        settle();
        chk("waw_stall", {31'd0, rsv_ready}, 32'd0);
        chk("waw_hazard_b", {31'd0, hazard}, 32'd1);
        adv();
        req_valid = 3'b001; ra[0] = 4'd3; rd[0] = 16'h0303;
        settle();
        chk("waw_pending_hold", {16'd0, pending}, 32'h0008);
        chk("waw_stall2", {31'd0, rsv_ready}, 32'd0);
        adv();
        req_valid = 3'b000;
        settle();
        chk("waw_wr_en", {16'd0, wr_en}, 32'h0008);
        chk("waw_no_lookahead", {31'd0, rsv_ready}, 32'd0);
        adv();
        settle();
        chk("waw_pending_clr", {16'd0, pending}, 32'h0);
        chk("waw_rsv_ok", {31'd0, rsv_ready}, 32'd1);
        adv();
        rsv_valid = 1'b0;
        settle();
        chk("waw_rsv_set", {16'd0, pending}, 32'h0008);
        adv();

        // set/clear collision on r2, then flush with a write in flight
        idle();
        req_valid = 3'b100; ra[2] = 4'd2; rd[2] = 16'h0D0D;
        settle(); chk("col_dbg_grant", {29'd0, req_ready}, 32'h4);
        adv();
        req_valid = 3'b000; rsv_valid = 1'b1; rsv_addr = 4'd2;
        settle();
        chk("col_wr_en", {16'd0, wr_en}, 32'h0004);
        chk("col_rsv_ready", {31'd0, rsv_ready}, 32'd1);
        adv();
        rsv_valid = 1'b0; req_valid = 3'b010; ra[1] = 4'd9; rd[1] = 16'h9999;
        settle(); chk("col_set_wins", {16'd0, pending}, 32'h000C);
        adv();
        req_valid = 3'b000; flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 4'd5;
        settle();
        chk("fl_wr_en", {16'd0, wr_en}, 32'h0200);
        chk("fl_wr_data", {16'd0, wr_data}, 32'h9999);
        chk("fl_rsv_blocked", {31'd0, rsv_ready}, 32'd0);
        adv();
        flush = 1'b0; rsv_valid = 1'b0;
        settle();
        chk("fl_pending", {16'd0, pending}, 32'h0);
        chk("fl_wr_en_done", {16'd0, wr_en}, 32'h0);
        adv();

        // asynchronous reset with a registered write to r8
        idle();
        req_valid = 3'b001; ra[0] = 4'd8; rd[0] = 16'h8888;
        rsv_valid = 1'b1; rsv_addr = 4'd8;
        settle(); adv();
        idle();
        req_valid = 3'b111;
        settle();
        chk("ar_pre_wr_en", {16'd0, wr_en}, 32'h0100);
        chk("ar_pre_pending", {16'd0, pending}, 32'h0100);
        rst = 1'b0;
        #1;
        chk("ar_wr_en", {16'd0, wr_en}, 32'h0);
        chk("ar_pending", {16'd0, pending}, 32'h0);
        chk("ar_req_ready", {29'd0, req_ready}, 32'h0);
        model_reset();
        adv();
        rst = 1'b1;
        settle();
        chk("ar_first_grant", {29'd0, req_ready}, 32'h1);
        adv();

        // randomized run against the model
        idle();
        for (int c = 0; c < 400; c++) begin
            req_valid = 3'($urandom_range(0, 7));
            for (int j = 0; j < 3; j++) begin
                ra[j] = 4'($urandom);
                rd[j] = 16'($urandom);
            end
            rsv_valid = ($urandom_range(0, 2) == 0);
            rsv_addr  = 4'($urandom);
            chk_a     = 4'($urandom);
            chk_b     = 4'($urandom);
            chk_valid = 1'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            settle();
            adv();
        end
        idle();
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Owns the single write port of the LITE-16 register file, which takes one data bus plus a 16-bit one-hot enable. It round-robin arbitrates write requests from execute writeback, memory load return and the debug port, and drives the registered data/enable pair. It also keeps a pending-write scoreboard, updated by issue-time reservations, and gives the fetch/decode stage an operand hazard flag and a WAW stall.

Parameters:
NREQ, 3, number of write requesters (index 0 = execute, 1 = memory, 2 = debug)
DW, 16, data width
NREG, 16, number of registers; address width AW = 4, fixed

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester write request
req_ready  out  NREQ  per-requester grant; a transfer happens when valid and ready are both high
req_addr  in  NREQ*AW  flattened destination register indices, requester i at [i*AW +: AW]
req_data  in  NREQ*DW  flattened write data, requester i at [i*DW +: DW]
rsv_valid  in  1  issue stage reserves a destination
rsv_addr  in  AW  register being reserved
rsv_ready  out  1  reservation accepted
chk_a  in  AW  operand A register index
chk_b  in  AW  operand B register index
chk_valid  in  1  the chk_a/chk_b indices are meaningful
hazard  out  1  an operand register has a pending write
flush  in  1  clears all reservations
wr_en  out  NREG  one-hot register-file enable
wr_data  out  DW  register-file write data
pending  out  NREG  scoreboard state, for observation

Behaviour:
- Reset (rst low, asynchronous): wr_en = 0, wr_data = 0, pending = 0, round-robin pointer = NREQ-1 (so requester 0 has priority first). Outputs are held while rst is low.
- Arbitration is combinational. Search starts at index (ptr+1) mod NREQ and wraps. The first valid requester gets req_ready high. At most one req_ready bit is high. req_ready is 0 when no requester is valid or when rst is low.
- The write port never back-pressures, so the scheduler accepts one write every cycle a request is valid.
- Accept in cycle N:
  - at edge N+1: wr_en gets the one-hot of req_addr, wr_data gets req_data, ptr gets the granted index;
  - at edge N+2: the register file captures the data.
  - With no grant: wr_en = 0 at the next edge, wr_data holds its value, ptr is unchanged.
- Pending clear: at every edge where wr_en is nonzero, pending &= ~wr_en. The clear lands on the same edge as the register-file capture.
- Reservation:
  - rsv_ready = rsv_valid & ~pending[rsv_addr] & ~flush. It is combinational and does not look ahead to a clear in the same cycle.
  - When the reservation is accepted, pending[rsv_addr] is set at the edge.
  - If a set and a clear hit the same bit at the same edge, the set wins.
- Writes to unreserved registers are legal (for example from the debug port). They write normally and leave pending unchanged.
- hazard = chk_valid & (pending[chk_a] | pending[chk_b]). It is combinational from registered state and deasserts in the cycle after the register-file capture edge.
- flush:
  - Next pending = 0. It overrides both clears and a same-cycle reservation.
  - Writes already registered, or accepted in the flush cycle, still complete.
- Reset asserted mid-operation: any registered write is dropped (wr_en forced to 0) and the scoreboard is cleared.
- No arithmetic; all indices are used modulo their widths.

Decomposition:
- Package lite16_pkg holds:
  - NREG, DW and AW;
  - requester index constants REQ_EXE = 0, REQ_MEM = 1, REQ_DBG = 2;
  - a function that returns the one-hot decode of an AW-bit index.
- Sub-module rr_arbiter (parameter NREQ) holds the combinational round-robin grant and the pointer register, and takes clk and rst.
- The scoreboard, reservation logic and output registers stay in the top module.

Test Plan:
- Single write: requester 0 writes addr 5, data 16'hBEEF in cycle 0 -> req_ready = 3'b001 in cycle 0; wr_en = 16'h0020 and wr_data = 16'hBEEF in cycle 1; wr_en = 0 in cycle 2.
- Round robin: all three requesters valid continuously for 6 cycles -> grants in order 0,1,2,0,1,2 with exactly one req_ready bit high per cycle.
- Scoreboard lifecycle:
  - reserve r7 in cycle 0, with chk_a = 7 and chk_valid = 1 held from cycle 1;
  - execute writes r7 in cycle 3;
  - required: pending[7] = 1 in cycles 1-4, hazard = 1 in cycles 1-4, hazard = 0 in cycle 5.
- WAW stall: with r3 pending, rsv_valid = 1 and rsv_addr = 3 -> rsv_ready = 0 and pending unchanged. After the write to r3 completes, the same request gives rsv_ready = 1.
- Set/clear collision and flush:
  - reserve r2 on the same edge that wr_en[2] clears it -> pending[2] = 1 afterwards;
  - then assert flush with a write in flight -> pending = 0, and the in-flight wr_en still pulses.
- Async reset: drop rst to 0 mid-cycle while wr_en = 16'h0100 -> wr_en = 0 and pending = 0 immediately, without waiting for a clock edge. After release, the first grant goes to requester 0.
